// File: rtl/p2s_tx_arbiter.sv
// p2s_tx_arbiter: round-robin scheduler that shares one parallel-to-serial
// converter between NUM_REQ byte sources. One byte is accepted per frame and
// handed to the converter with a single-cycle load pulse. The next byte is
// held off until the frame has shifted out, plus an optional idle gap.
module p2s_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SERIAL_LEN = 8,
  parameter int GAP_CYCLES = 0,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 load,
  output logic [7:0]           parallel_in,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;

  // Counters are loaded with "cycles remaining minus one" and stop at zero.
  localparam logic [7:0] SHIFT_LAST = 8'(SERIAL_LEN - 1);
  localparam logic [7:0] GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit         HAS_GAP    = (GAP_CYCLES > 0);

  state_e         state_q, state_d;
  logic [7:0]     shift_cnt_q, shift_cnt_d;
  logic [7:0]     gap_cnt_q, gap_cnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     data_q, data_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           load_q, load_d;

  logic           sel_found;
  logic [IDW-1:0] sel_idx;
  logic [7:0]     sel_byte;
  logic           accept;

  // Index of the requester 'offset' positions after 'ptr', wrapping at NUM_REQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] ptr, input int offset);
    int sum;
    sum = int'(ptr) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDW'(sum);
  endfunction

  // Round-robin search: first valid requester after the last one granted.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found && req_valid[rr_index(ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = rr_index(ptr_q, k);
      end
    end
  end

  // Byte mux: only the selected lane is ever routed, so junk elsewhere is ignored.
  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_found && (sel_idx == IDW'(i))) sel_byte = req_data[8*i +: 8];
    end
  end

  assign accept = (state_q == IDLE) && sel_found;

  // One-hot ready toward the chosen requester, only while idle.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[sel_idx] = 1'b1;
  end

  // Next-state logic: IDLE -> LOAD -> SHIFT (SERIAL_LEN cycles) -> [GAP] -> IDLE.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    grant_d     = grant_q;
    load_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = sel_byte;
          grant_d = sel_idx;
          ptr_d   = sel_idx;
          load_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_cnt_d = SHIFT_LAST;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (shift_cnt_q == 8'd0) begin
          if (HAS_GAP) begin
            gap_cnt_d = GAP_LAST;
            state_d   = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift_cnt_d = shift_cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_cnt_q <= 8'd0;
      gap_cnt_q   <= 8'd0;
      ptr_q       <= IDW'(NUM_REQ - 1);
      data_q      <= 8'h00;
      grant_q     <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      load_q      <= load_d;
    end
  end

  assign load        = load_q;
  assign parallel_in = data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == SHIFT) && (shift_cnt_q == 8'd0);

endmodule

// File: tb/tb_p2s_tx_arbiter.sv
// tb_p2s_tx_arbiter: self-checking bench for p2s_tx_arbiter. Two instances share
// the same requester inputs: one without an idle gap, one with a 3-cycle gap.
module tb_p2s_tx_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int SERIAL_LEN = 8;
  localparam int IDLE_SINCE = 1000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   reqValid;
  logic [NUM_REQ*8-1:0] reqData;

  logic [NUM_REQ-1:0] readyO     [2];
  logic               loadO      [2];
  logic [7:0]         parO       [2];
  logic [1:0]         grantO     [2];
  logic               busyO      [2];
  logic               frameDoneO [2];

  int assertCount = 0;
  int failCount   = 0;
  int gapOf [2]   = '{0, 3};

  // Reference model state: cycles since last handshake, RR pointer, held outputs
  int         mSince [2];
  int         mPtr   [2];
  logic [7:0] mByte  [2];
  logic [1:0] mGrant [2];
  logic [3:0] acceptedLast;

  // Load-pulse log used by the timing sequences
  int         nLoads [2];
  int         loadT  [2][8];
  int         loadG  [2][8];
  logic [7:0] loadB  [2][8];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  expReady;
    logic [1:0]  expGrant;
    logic [7:0]  expByte;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  p2s_tx_arbiter #(.NUM_REQ(NUM_REQ), .SERIAL_LEN(SERIAL_LEN), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_data(reqData),
    .req_ready(readyO[0]), .load(loadO[0]), .parallel_in(parO[0]),
    .grant_id(grantO[0]), .busy(busyO[0]), .frame_done(frameDoneO[0])
  );

  p2s_tx_arbiter #(.NUM_REQ(NUM_REQ), .SERIAL_LEN(SERIAL_LEN), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_data(reqData),
    .req_ready(readyO[1]), .load(loadO[1]), .parallel_in(parO[1]),
    .grant_id(grantO[1]), .busy(busyO[1]), .frame_done(frameDoneO[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int u = 0; u < 2; u++) begin
      mSince[u] = IDLE_SINCE;
      mPtr[u]   = NUM_REQ - 1;
      mByte[u]  = 8'h00;
      mGrant[u] = 2'd0;
    end
    acceptedLast = '0;
  endtask

  task automatic doReset();
    reqValid = '0;
    reqData  = '0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  // First valid requester after ptr, with wrap; -1 when none
  function automatic int pickNext(input int ptr, input logic [3:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Compare one instance against the model for this cycle, then advance the model
  task automatic modelStep(input int u, input int cyc);
    int         frameLen;
    bit         idle;
    int         pick;
    logic [3:0] expReady;
    frameLen = 1 + SERIAL_LEN + gapOf[u];
    idle     = (mSince[u] > frameLen);
    pick     = idle ? pickNext(mPtr[u], reqValid) : -1;
    expReady = (pick >= 0) ? 4'(1 << pick) : 4'b0000;
    checkOutput($sformatf("rand c%0d u%0d ready", cyc, u), readyO[u], expReady);
    checkOutput($sformatf("rand c%0d u%0d load", cyc, u), loadO[u], mSince[u] == 1);
    checkOutput($sformatf("rand c%0d u%0d busy", cyc, u), busyO[u], !idle);
    checkOutput($sformatf("rand c%0d u%0d done", cyc, u), frameDoneO[u], mSince[u] == 1 + SERIAL_LEN);
    checkOutput($sformatf("rand c%0d u%0d byte", cyc, u), parO[u], mByte[u]);
    checkOutput($sformatf("rand c%0d u%0d grant", cyc, u), grantO[u], mGrant[u]);
    if (pick >= 0) begin
      mPtr[u]            = pick;
      mSince[u]          = 1;
      mByte[u]           = reqData[8*pick +: 8];
      mGrant[u]          = 2'(pick);
      acceptedLast[pick] = 1'b1;
    end else if (mSince[u] < IDLE_SINCE) begin
      mSince[u]++;
    end
  endtask

  // One table entry: offer, check ready, check the load cycle, then time the frame
  task automatic applyStimulus(input vec_t v, input int idx);
    int busyCycles;
    int donePos;
    bit granted;
    granted = (v.expReady != 4'b0000);
    @(negedge clk);
    reqValid = v.valid;
    reqData  = v.data;
    #1;
    checkOutput($sformatf("vec%0d ready", idx), readyO[0], v.expReady);
    @(negedge clk);
    reqValid = '0;
    #1;
    checkOutput($sformatf("vec%0d load", idx), loadO[0], granted);
    checkOutput($sformatf("vec%0d byte", idx), parO[0], v.expByte);
    checkOutput($sformatf("vec%0d grant", idx), grantO[0], v.expGrant);
    busyCycles = 0;
    donePos    = -1;
    for (int c = 0; c < 30 && busyO[0]; c++) begin
      if (frameDoneO[0]) donePos = c;
      busyCycles++;
      @(negedge clk);
      #1;
    end
    checkOutput($sformatf("vec%0d busyLen", idx), busyCycles, granted ? SERIAL_LEN + 1 : 0);
    checkOutput($sformatf("vec%0d donePos", idx), donePos, granted ? SERIAL_LEN : -1);
  endtask

  // Log load pulses of both instances; ready must stay low while busy
  task automatic runLoads(input int cycles);
    nLoads = '{0, 0};
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        if (loadO[u] && nLoads[u] < 8) begin
          loadT[u][nLoads[u]] = c;
          loadG[u][nLoads[u]] = int'(grantO[u]);
          loadB[u][nLoads[u]] = parO[u];
          nLoads[u]++;
        end
        if (busyO[u]) checkOutput($sformatf("busyReady u%0d c%0d", u, c), readyO[u], 4'b0000);
      end
    end
  endtask

  // Data is 43322110, so requester g carries byte 16+17*g
  task automatic checkLoads(input string tag, input int need, input bit rotate);
    int g;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("%s u%0d loadCount", tag, u), nLoads[u] >= need, 1);
      for (int k = 0; k < need && k < nLoads[u]; k++) begin
        g = rotate ? (k % NUM_REQ) : 0;
        checkOutput($sformatf("%s u%0d grant%0d", tag, u, k), loadG[u][k], g);
        checkOutput($sformatf("%s u%0d byte%0d", tag, u, k), loadB[u][k], 8'(16 + 17 * g));
        checkOutput($sformatf("%s u%0d time%0d", tag, u, k), loadT[u][k],
                    k * (SERIAL_LEN + gapOf[u] + 2));
      end
    end
  endtask

  // Main sequence: reset state, vector table, timing sequences, random run
  initial begin
    vecs[0]  = '{4'b1111, 32'h433221A5, 4'b0001, 2'd0, 8'hA5};
    vecs[1]  = '{4'b1111, 32'h43322110, 4'b0010, 2'd1, 8'h21};
    vecs[2]  = '{4'b1111, 32'h43322110, 4'b0100, 2'd2, 8'h32};
    vecs[3]  = '{4'b0011, 32'h43322110, 4'b0001, 2'd0, 8'h10};
    vecs[4]  = '{4'b0011, 32'h43322110, 4'b0010, 2'd1, 8'h21};
    vecs[5]  = '{4'b0011, 32'h43322110, 4'b0001, 2'd0, 8'h10};
    vecs[6]  = '{4'b1000, 32'h43322110, 4'b1000, 2'd3, 8'h43};
    vecs[7]  = '{4'b1111, 32'h43322110, 4'b0001, 2'd0, 8'h10};
    vecs[8]  = '{4'b0110, 32'h43322110, 4'b0010, 2'd1, 8'h21};
    vecs[9]  = '{4'b0101, 32'h43322110, 4'b0100, 2'd2, 8'h32};
    vecs[10] = '{4'b0000, 32'h43322110, 4'b0000, 2'd2, 8'h32};
    vecs[11] = '{4'b1010, 32'h43322110, 4'b1000, 2'd3, 8'h43};

    doReset();
    #1;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("reset u%0d ready", u), readyO[u], 4'b0000);
      checkOutput($sformatf("reset u%0d load", u), loadO[u], 1'b0);
      checkOutput($sformatf("reset u%0d byte", u), parO[u], 8'h00);
      checkOutput($sformatf("reset u%0d grant", u), grantO[u], 2'd0);
      checkOutput($sformatf("reset u%0d busy", u), busyO[u], 1'b0);
      checkOutput($sformatf("reset u%0d done", u), frameDoneO[u], 1'b0);
    end

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // All four requesters held valid: rotation and frame spacing
    doReset();
    reqValid = 4'b1111;
    reqData  = 32'h43322110;
    runLoads(70);
    checkLoads("rr", 5, 1'b1);

    // Single requester held valid: back-to-back grants
    doReset();
    reqValid = 4'b0001;
    reqData  = 32'h43322110;
    runLoads(45);
    checkLoads("single", 4, 1'b0);

    // Requester 1 appears during SHIFT and withdraws before IDLE
    doReset();
    @(negedge clk);
    reqValid = 4'b0001;
    reqData  = 32'h43322110;
    @(negedge clk);
    reqValid = '0;
    #1;
    checkOutput("withdraw load", loadO[0], 1'b1);
    repeat (2) @(negedge clk);
    reqValid = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("withdraw shiftReady%0d", c), readyO[0], 4'b0000);
    end
    checkOutput("withdraw lastShiftDone", frameDoneO[0], 1'b1);
    reqValid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("withdraw idleLoad%0d", c), loadO[0], 1'b0);
      checkOutput($sformatf("withdraw idleBusy%0d", c), busyO[0], 1'b0);
      checkOutput($sformatf("withdraw idleReady%0d", c), readyO[0], 4'b0000);
    end

    // Asynchronous reset during SHIFT cycle 4, then recovery
    doReset();
    @(negedge clk);
    reqValid = 4'b0100;
    reqData  = 32'h43322110;
    @(negedge clk);
    reqValid = '0;
    #1;
    checkOutput("midReset grant2", grantO[0], 2'd2);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("midReset busyBefore", busyO[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset load", loadO[0], 1'b0);
    checkOutput("midReset busy", busyO[0], 1'b0);
    checkOutput("midReset busy u1", busyO[1], 1'b0);
    checkOutput("midReset byte", parO[0], 8'h00);
    checkOutput("midReset grant", grantO[0], 2'd0);
    checkOutput("midReset done", frameDoneO[0], 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    reqValid = 4'b1000;
    #1;
    checkOutput("midReset readyAfter", readyO[0], 4'b1000);
    @(negedge clk);
    reqValid = '0;
    #1;
    checkOutput("midReset loadAfter", loadO[0], 1'b1);
    checkOutput("midReset grantAfter", grantO[0], 2'd3);
    checkOutput("midReset byteAfter", parO[0], 8'h43);

    // Random requesters against the reference model, dense then sparse traffic
    doReset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (reqValid[i] && !acceptedLast[i]) begin
          if ($urandom_range(7) == 0) reqValid[i] = 1'b0;
        end else begin
          reqValid[i]       = (c < 400) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
          reqData[8*i +: 8] = 8'($urandom);
        end
      end
      acceptedLast = '0;
      #1;
      for (int u = 0; u < 2; u++) modelStep(u, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
